glitch_monitor: RTL and testbench
=================================

# glitch_monitor

Measurement block for the glitch bench. It watches the same `trigger` and `glitch` wires the glitch generator drives or consumes, in the PLL clock domain. It reports, in clock cycles, the delay from the trigger rising edge to the glitch rising edge, and the glitch width. It is used for closed-loop checking of delay and width settings on hardware and in simulation, and it also flags glitches that appear with no trigger.

## Interface
- `COUNT_WIDTH`, 32: width of the measurement counters and result ports.
- `TIMEOUT_CYCLES`, 32'd204_000_000: number of DELAY cycles without a glitch before the measurement is abandoned. This is 1 s at 204 MHz. It must be < 2^COUNT_WIDTH − 1.

- `clk`  in  1  measurement clock (PLL output domain).
- `reset`  in  1  synchronous, active-high reset.
- `trigger`  in  1  trigger level, same signal fed to the generator.
- `glitch`  in  1  glitch pulse under measurement.
- `busy`  out  1  high in DELAY, PULSE and HOLD.
- `result_valid`  out  1  one-cycle strobe when a new result is loaded.
- `delay_cycles`  out  COUNT_WIDTH  cycles glitch was sampled low in DELAY.
- `width_cycles`  out  COUNT_WIDTH  cycles glitch was sampled high in PULSE.
- `timed_out`  out  1  last result ended by timeout; width_cycles = 0.
- `saturated`  out  1  a counter hit all-ones during the last measurement.
- `spurious_glitch`  out  1  sticky: a glitch rising edge was seen outside DELAY.

## Operation
- `trig_rise` = trigger & ~trig_q. `glit_rise` = glitch & ~glit_q. `trig_q` and `glit_q` are one-cycle delayed samples.
- **States:** IDLE, DELAY, PULSE, HOLD.
- **IDLE**
  - On `trig_rise`: go to DELAY and clear both counters.
  - `glitch` is ignored for measurement in this state.
- **DELAY**
  - glitch = 1: go to PULSE, width counter <= 1.
  - Otherwise, if trigger = 0: abort to IDLE. No result, no strobe.
  - Otherwise, if delay counter == TIMEOUT_CYCLES: go to HOLD and load results with timed_out = 1 and width_cycles = 0.
  - Otherwise: delay counter saturating-increments.
- **PULSE**
  - glitch = 1: width counter saturating-increments.
  - glitch = 0: load results with timed_out = 0, go to HOLD.
  - `trigger` is ignored in this state.
- **HOLD**
  - Wait for trigger = 0, then go to IDLE.
  - This enforces one measurement per trigger assertion.
- **Result load**
  - `delay_cycles`, `width_cycles`, `timed_out` and `saturated` update on the load edge.
  - `result_valid` = 1 for exactly that following cycle.
  - Results hold until the next load.
- **Saturation:** counters stop at 2^COUNT_WIDTH − 1. `saturated` is set if either counter reached that value.
- **Spurious glitches:** a `glit_rise` in IDLE or HOLD sets `spurious_glitch`. Only `reset` clears it.

## Timing
- **Reset:** all outputs are 0, state is IDLE, and `trig_q`/`glit_q` are 0.
- **Delay count:** trigger rises at cycle T, glitch first sampled high at cycle G > T. Then `delay_cycles` = G − T − 1.
  - Glitch high at T and still high at T+1 gives delay 0.
- **Width count:** `width_cycles` equals the number of consecutive high samples.
- **Result strobe:** `result_valid` is asserted the cycle after the first low sample in PULSE.
- **Timeout:** `result_valid` follows TIMEOUT_CYCLES+1 DELAY cycles.
- **Minimum pulse:** a one-cycle glitch gives width 1.
- **Reset mid-measurement:** returns to IDLE the next cycle. No strobe is issued, and results clear to 0.
- **Back-to-back triggers:** a trigger can be re-measured 2 cycles after it falls.
  - HOLD→IDLE takes one cycle.
  - A new `trig_rise` needs `trig_q` = 0.

## Configuration
- `GLITCH_MON_SYNC_EN`
  - **Defined:** `trigger` and `glitch` each pass through a two-flop synchronizer before edge detection. This adds 2 cycles of input-to-state latency on both paths. Measured delay and width for clean inputs are unchanged.
  - **Undefined:** inputs are sampled directly, so both must already be synchronous to `clk`.

## Test plan
- **Nominal:** reset, trigger high at cycle 10, glitch high cycles 110–149, trigger low at 200. Expect `delay_cycles` = 99, `width_cycles` = 40, `timed_out` = 0, and `result_valid` one cycle at 151.
- **Timeout:** TIMEOUT_CYCLES = 20, trigger high, no glitch. Expect `result_valid` after 21 DELAY cycles, `timed_out` = 1, `width_cycles` = 0, and `busy` high until trigger falls.
- **Abort and spurious:** trigger high for 5 cycles then low with no glitch. Expect no `result_valid` and return to IDLE. Then pulse glitch in IDLE and expect `spurious_glitch` = 1 until reset.
- **Saturation:** COUNT_WIDTH = 4, delay of 3 cycles, glitch held 30 cycles. Expect `width_cycles` = 15 and `saturated` = 1.
- **Reset mid-PULSE:** assert reset during the glitch. Expect all outputs 0 next cycle and no strobe. A following trigger measures correctly.
- **Edge cases:** glitch high on the same cycle as the trigger rise gives `delay_cycles` = 0. Repeat the nominal case with `GLITCH_MON_SYNC_EN` defined and expect identical results with `result_valid` 2 cycles later.

Source files
------------

// File: rtl/glitch_monitor.sv
// Measures trigger-rise-to-glitch delay and glitch width in clk cycles, flags glitches seen outside a measurement.
// Optional GLITCH_MON_SYNC_EN adds a two-flop synchronizer on trigger and glitch ahead of edge detection.
module glitch_monitor #(
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 32'd204_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic                   glitch,
    output logic                   busy,
    output logic                   result_valid,
    output logic [COUNT_WIDTH-1:0] delay_cycles,
    output logic [COUNT_WIDTH-1:0] width_cycles,
    output logic                   timed_out,
    output logic                   saturated,
    output logic                   spurious_glitch
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CNT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_HOLD
    } state_t;

    logic trig_in;
    logic glit_in;

`ifdef GLITCH_MON_SYNC_EN
    logic trig_meta_q, trig_sync_q;
    logic glit_meta_q, glit_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            glit_meta_q <= 1'b0;
            glit_sync_q <= 1'b0;
        end else begin
            trig_meta_q <= trigger;
            trig_sync_q <= trig_meta_q;
            glit_meta_q <= glitch;
            glit_sync_q <= glit_meta_q;
        end
    end

    assign trig_in = trig_sync_q;
    assign glit_in = glit_sync_q;
`else
    assign trig_in = trigger;
    assign glit_in = glitch;
`endif

    state_t                 state_q, state_d;
    logic                   trig_q, trig_d;
    logic                   glit_q, glit_d;
    logic [COUNT_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [COUNT_WIDTH-1:0] width_cnt_q, width_cnt_d;
    logic                   busy_q, busy_d;
    logic                   result_valid_q, result_valid_d;
    logic [COUNT_WIDTH-1:0] delay_cycles_q, delay_cycles_d;
    logic [COUNT_WIDTH-1:0] width_cycles_q, width_cycles_d;
    logic                   timed_out_q, timed_out_d;
    logic                   saturated_q, saturated_d;
    logic                   spurious_q, spurious_d;

    logic trig_rise;
    logic glit_rise;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign trig_rise = trig_in & ~trig_q;
    assign glit_rise = glit_in & ~glit_q;

    always_comb begin
        state_d        = state_q;
        trig_d         = trig_in;
        glit_d         = glit_in;
        delay_cnt_d    = delay_cnt_q;
        width_cnt_d    = width_cnt_q;
        result_valid_d = 1'b0;
        delay_cycles_d = delay_cycles_q;
        width_cycles_d = width_cycles_q;
        timed_out_d    = timed_out_q;
        saturated_d    = saturated_q;
        spurious_d     = spurious_q;

        unique case (state_q)
            ST_IDLE: begin
                if (glit_rise) spurious_d = 1'b1;
                if (trig_rise) begin
                    state_d     = ST_DELAY;
                    delay_cnt_d = '0;
                    width_cnt_d = '0;
                end
            end
            ST_DELAY: begin
                // Glitch takes priority over a falling trigger or timeout on the same sample.
                if (glit_in) begin
                    state_d     = ST_PULSE;
                    width_cnt_d = CNT_ONE;
                end else if (!trig_in) begin
                    state_d = ST_IDLE;
                end else if (delay_cnt_q == TIMEOUT_CNT) begin
                    state_d        = ST_HOLD;
                    result_valid_d = 1'b1;
                    delay_cycles_d = delay_cnt_q;
                    width_cycles_d = '0;
                    timed_out_d    = 1'b1;
                    saturated_d    = (delay_cnt_q == CNT_MAX);
                end else begin
                    delay_cnt_d = sat_inc(delay_cnt_q);
                end
            end
            ST_PULSE: begin
                if (glit_in) begin
                    width_cnt_d = sat_inc(width_cnt_q);
                end else begin
                    state_d        = ST_HOLD;
                    result_valid_d = 1'b1;
                    delay_cycles_d = delay_cnt_q;
                    width_cycles_d = width_cnt_q;
                    timed_out_d    = 1'b0;
                    saturated_d    = (delay_cnt_q == CNT_MAX) || (width_cnt_q == CNT_MAX);
                end
            end
            ST_HOLD: begin
                if (glit_rise) spurious_d = 1'b1;
                if (!trig_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            trig_q         <= 1'b0;
            glit_q         <= 1'b0;
            delay_cnt_q    <= '0;
            width_cnt_q    <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            delay_cycles_q <= '0;
            width_cycles_q <= '0;
            timed_out_q    <= 1'b0;
            saturated_q    <= 1'b0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_q         <= trig_d;
            glit_q         <= glit_d;
            delay_cnt_q    <= delay_cnt_d;
            width_cnt_q    <= width_cnt_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            delay_cycles_q <= delay_cycles_d;
            width_cycles_q <= width_cycles_d;
            timed_out_q    <= timed_out_d;
            saturated_q    <= saturated_d;
            spurious_q     <= spurious_d;
        end
    end

    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign delay_cycles    = delay_cycles_q;
    assign width_cycles    = width_cycles_q;
    assign timed_out       = timed_out_q;
    assign saturated       = saturated_q;
    assign spurious_glitch = spurious_q;

endmodule

// File: tb/tb_glitch_monitor.sv
// Directed bench for glitch_monitor: three instances (nominal, short timeout, 4-bit counters) share stimulus;
// expected results are queued per instance and checked when each result_valid strobe appears.
module tb_glitch_monitor;

`ifdef GLITCH_MON_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    typedef struct {
        logic [31:0] delay;
        logic [31:0] width;
        logic        to;
        logic        sat;
        int          at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic trigger;
    logic glitch;

    logic        m_busy, m_rv, m_to, m_sat, m_spur;
    logic [31:0] m_delay, m_width;
    logic        t_busy, t_rv, t_to, t_sat, t_spur;
    logic [31:0] t_delay, t_width;
    logic        s_busy, s_rv, s_to, s_sat, s_spur;
    logic [3:0]  s_delay, s_width;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int b;

    exp_t q_m[$];
    exp_t q_t[$];
    exp_t q_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    glitch_monitor #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(1000)) u_m (
        .clk(clk), .reset(reset), .trigger(trigger), .glitch(glitch),
        .busy(m_busy), .result_valid(m_rv), .delay_cycles(m_delay), .width_cycles(m_width),
        .timed_out(m_to), .saturated(m_sat), .spurious_glitch(m_spur)
    );

    glitch_monitor #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(20)) u_t (
        .clk(clk), .reset(reset), .trigger(trigger), .glitch(glitch),
        .busy(t_busy), .result_valid(t_rv), .delay_cycles(t_delay), .width_cycles(t_width),
        .timed_out(t_to), .saturated(t_sat), .spurious_glitch(t_spur)
    );

    glitch_monitor #(.COUNT_WIDTH(4), .TIMEOUT_CYCLES(10)) u_s (
        .clk(clk), .reset(reset), .trigger(trigger), .glitch(glitch),
        .busy(s_busy), .result_valid(s_rv), .delay_cycles(s_delay), .width_cycles(s_width),
        .timed_out(s_to), .saturated(s_sat), .spurious_glitch(s_spur)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t e, input logic [31:0] d,
                           input logic [31:0] w, input logic to, input logic sat);
        check({tag, " strobe edge"}, edge_n, e.at_edge);
        check({tag, " delay"}, d, e.delay);
        check({tag, " width"}, w, e.width);
        check({tag, " timed_out"}, to, e.to);
        check({tag, " saturated"}, sat, e.sat);
    endtask

    always @(negedge clk) begin
        if (m_rv === 1'b1) begin
            if (q_m.size() == 0) check("m unexpected strobe", edge_n, 0);
            else chk_res("m", q_m.pop_front(), m_delay, m_width, m_to, m_sat);
        end
    end

    always @(negedge clk) begin
        if (t_rv === 1'b1) begin
            if (q_t.size() == 0) check("t unexpected strobe", edge_n, 0);
            else chk_res("t", q_t.pop_front(), t_delay, t_width, t_to, t_sat);
        end
    end

    always @(negedge clk) begin
        if (s_rv === 1'b1) begin
            if (q_s.size() == 0) check("s unexpected strobe", edge_n, 0);
            else chk_res("s", q_s.pop_front(), {28'd0, s_delay}, {28'd0, s_width}, s_to, s_sat);
        end
    end

    // Returns just after edge k-1, so inputs assigned next are sampled at edge k.
    task automatic go(input int k);
        while (edge_n < k - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        trigger = 1'b0;
        glitch  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        trigger = 1'b0;
        glitch  = 1'b0;
        go(4);
        check("reset busy", {m_busy, t_busy, s_busy}, 0);
        check("reset valid", {m_rv, t_rv, s_rv}, 0);
        check("reset delay", m_delay, 0);
        check("reset width", m_width, 0);
        check("reset flags", {m_to, m_sat, m_spur, s_to, s_sat, s_spur}, 0);
        reset = 1'b0;

        // Nominal: short-timeout instances time out and then see the glitch in HOLD.
        b = edge_n;
        go(b + 10); trigger = 1'b1;
        q_m.push_back('{32'd99, 32'd40, 1'b0, 1'b0, b + 150 + S});
        q_t.push_back('{32'd20, 32'd0,  1'b1, 1'b0, b + 31 + S});
        q_s.push_back('{32'd10, 32'd0,  1'b1, 1'b0, b + 21 + S});
        go(b + 60);  check("nominal busy mid", m_busy, 1);
        go(b + 110); glitch = 1'b1;
        go(b + 150); glitch = 1'b0;
        go(b + 200); trigger = 1'b0;
        check("nominal t busy hold", t_busy, 1);
        go(b + 205 + S);
        check("nominal m busy after", m_busy, 0);
        check("nominal t busy after", t_busy, 0);
        check("nominal m delay held", m_delay, 99);
        check("nominal m spurious", m_spur, 0);
        check("nominal t spurious", t_spur, 1);
        check("nominal s spurious", s_spur, 1);
        do_reset();

        // Timeout: trigger high 40 cycles, no glitch; main instance aborts silently.
        b = edge_n;
        go(b + 5); trigger = 1'b1;
        q_t.push_back('{32'd20, 32'd0, 1'b1, 1'b0, b + 26 + S});
        q_s.push_back('{32'd10, 32'd0, 1'b1, 1'b0, b + 16 + S});
        go(b + 41);
        check("timeout t busy", t_busy, 1);
        check("timeout m busy", m_busy, 1);
        go(b + 45); trigger = 1'b0;
        go(b + 47 + S);
        check("timeout t busy after fall", t_busy, 0);
        check("timeout m busy after abort", m_busy, 0);
        check("timeout t delay held", t_delay, 20);
        do_reset();

        // Abort then spurious glitch in IDLE.
        b = edge_n;
        go(b + 3); trigger = 1'b1;
        go(b + 8); trigger = 1'b0;
        go(b + 12 + S);
        check("abort busy", {m_busy, t_busy, s_busy}, 0);
        go(b + 20); glitch = 1'b1;
        go(b + 23); glitch = 1'b0;
        go(b + 30);
        check("spurious set", {m_spur, t_spur, s_spur}, 3'b111);
        go(b + 40);
        check("spurious sticky", m_spur, 1);
        do_reset();
        check("spurious cleared", {m_spur, t_spur, s_spur}, 0);

        // Saturation: delay 3, glitch held 30 cycles.
        b = edge_n;
        go(b + 5); trigger = 1'b1;
        q_m.push_back('{32'd3, 32'd30, 1'b0, 1'b0, b + 39 + S});
        q_t.push_back('{32'd3, 32'd30, 1'b0, 1'b0, b + 39 + S});
        q_s.push_back('{32'd3, 32'd15, 1'b0, 1'b1, b + 39 + S});
        go(b + 9);  glitch = 1'b1;
        go(b + 39); glitch = 1'b0;
        go(b + 45); trigger = 1'b0;
        go(b + 50 + S);
        check("sat s flag held", s_sat, 1);

        // Reset during PULSE, then a fresh measurement.
        b = edge_n;
        go(b + 5);  trigger = 1'b1;
        go(b + 10); glitch = 1'b1;
        go(b + 20); reset = 1'b1; trigger = 1'b0; glitch = 1'b0;
        go(b + 21);
        check("midrst busy", {m_busy, t_busy, s_busy}, 0);
        check("midrst valid", {m_rv, t_rv, s_rv}, 0);
        check("midrst m delay", m_delay, 0);
        check("midrst m width", m_width, 0);
        check("midrst s results", {s_delay, s_width, s_sat}, 0);
        reset = 1'b0;
        b = edge_n;
        go(b + 5); trigger = 1'b1;
        q_m.push_back('{32'd4, 32'd5, 1'b0, 1'b0, b + 15 + S});
        q_t.push_back('{32'd4, 32'd5, 1'b0, 1'b0, b + 15 + S});
        q_s.push_back('{32'd4, 32'd5, 1'b0, 1'b0, b + 15 + S});
        go(b + 10); glitch = 1'b1;
        go(b + 15); glitch = 1'b0;
        go(b + 20); trigger = 1'b0;

        // Glitch rising together with trigger: first DELAY sample is already high.
        b = edge_n + 5;
        go(b + 5); trigger = 1'b1; glitch = 1'b1;
        q_m.push_back('{32'd0, 32'd4, 1'b0, 1'b0, b + 10 + S});
        q_t.push_back('{32'd0, 32'd4, 1'b0, 1'b0, b + 10 + S});
        q_s.push_back('{32'd0, 32'd4, 1'b0, 1'b0, b + 10 + S});
        go(b + 10); glitch = 1'b0;
        go(b + 15); trigger = 1'b0;
        go(b + 30);

        check("m queue drained", q_m.size(), 0);
        check("t queue drained", q_t.size(), 0);
        check("s queue drained", q_s.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
